// File: rtl/or1k_dbus_wb_bridge.sv
// OR1K data-bus to Wishbone B3 master bridge.
// Single beats for plain accesses, wrapping incremental bursts for line refills.
module or1k_dbus_wb_bridge #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int BURST_WORDS          = 8,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dbus_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
    input  logic [3:0]                      dbus_bsel_i,
    input  logic                            dbus_we_i,
    input  logic                            dbus_burst_i,
    output logic                            dbus_ack_o,
    output logic                            dbus_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_o,
    output logic [3:0]                      wbm_sel_o,
    output logic                            wbm_we_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    input  logic                            wbm_rty_i
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int LW = $clog2(BURST_WORDS);
    localparam logic [1:0] BTE = (BURST_WORDS == 4) ? 2'b01 :
                                 (BURST_WORDS == 8) ? 2'b10 : 2'b11;
    localparam logic [LW-1:0] LAST = LW'(BURST_WORDS - 1);
    localparam logic [7:0]    TMO  = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, DONE} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  adr_q, adr_d;
    logic [W-1:0]  wdat_q, wdat_d;
    logic [W-1:0]  rdat_q, rdat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [2:0]    cti_q, cti_d;
    logic [1:0]    bte_q, bte_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [7:0]    wait_q, wait_d;
    logic          timeout;
    logic          fault;

    assign timeout = (TIMEOUT_CYCLES != 0) && (wait_q == TMO);
    // Retry and time-out are reported to the core exactly like a bus error.
    assign fault   = wbm_err_i | wbm_rty_i | timeout;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        beat_d  = beat_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (dbus_req_i) begin
                    adr_d  = dbus_adr_i;
                    wdat_d = dbus_dat_i;
                    we_d   = dbus_we_i;
                    cyc_d  = 1'b1;
                    wait_d = '0;
                    beat_d = '0;
                    if (dbus_burst_i && !dbus_we_i) begin
                        state_d = BURST;
                        sel_d   = 4'hF;
                        cti_d   = 3'b010;
                        bte_d   = BTE;
                    end else begin
                        state_d = SINGLE;
                        sel_d   = dbus_bsel_i;
                        cti_d   = 3'b000;
                        bte_d   = 2'b00;
                    end
                end
            end
            SINGLE, BURST: begin
                if (fault) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (wbm_ack_i) begin
                    ack_d  = 1'b1;
                    wait_d = '0;
                    if (state_q == SINGLE) begin
                        cyc_d   = 1'b0;
                        state_d = DONE;
                        if (!we_q) rdat_d = wbm_dat_i;
                    end else begin
                        rdat_d = wbm_dat_i;
                        if (beat_q == LAST) begin
                            cyc_d   = 1'b0;
                            state_d = DONE;
                        end else begin
                            beat_d           = beat_q + LW'(1);
                            // Wrap inside the cache line.
                            adr_d[LW+1:2]    = adr_q[LW+1:2] + LW'(1);
                            cti_d            = (beat_d == LAST) ? 3'b111 : 3'b010;
                        end
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            cti_q   <= '0;
            bte_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    assign dbus_ack_o = ack_q;
    assign dbus_err_o = err_q;
    assign dbus_dat_o = rdat_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = wdat_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_we_o   = we_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_cti_o  = cti_q;
    assign wbm_bte_o  = bte_q;

endmodule

// File: tb/tb_or1k_dbus_wb_bridge.sv
// Directed bench for or1k_dbus_wb_bridge: scripted Wishbone slave,
// bus-beat and read-data scoreboards, cycle-level latency checks.
module tb_or1k_dbus_wb_bridge;

    logic        clk;
    logic        rst;
    logic        dbus_req_i;
    logic [31:0] dbus_adr_i;
    logic [31:0] dbus_dat_i;
    logic [3:0]  dbus_bsel_i;
    logic        dbus_we_i;
    logic        dbus_burst_i;
    logic        dbus_ack_o;
    logic        dbus_err_o;
    logic [31:0] dbus_dat_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    or1k_dbus_wb_bridge #(
        .OPTION_OPERAND_WIDTH(32),
        .BURST_WORDS(8),
        .TIMEOUT_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst),
        .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i),
        .dbus_dat_i(dbus_dat_i), .dbus_bsel_i(dbus_bsel_i),
        .dbus_we_i(dbus_we_i), .dbus_burst_i(dbus_burst_i),
        .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o),
        .dbus_dat_o(dbus_dat_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;

    logic [73:0] bq[$];
    logic [32:0] dq[$];

    int          slv_waits    = 0;
    int          slv_err_beat = -1;
    bit          slv_ack_err  = 0;
    bit          slv_rty      = 0;
    bit          slv_silent   = 0;
    bit          slv_fixed    = 0;
    logic [31:0] slv_val      = '0;
    int          wcnt         = 0;
    int          beat         = 0;

    int req_cyc, acks, errs, first_ack, last_ack, err_cyc, stb_rise;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [73:0] pk(input logic [31:0] a, input logic [3:0] s,
                                       input logic w, input logic [2:0] c,
                                       input logic [1:0] b, input logic [31:0] d);
        return {a, s, w, c, b, d};
    endfunction

    function automatic logic [127:0] outs();
        return {18'd0, dbus_ack_o, dbus_err_o, dbus_dat_o, wbm_adr_o,
                wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
                wbm_cti_o, wbm_bte_o};
    endfunction

    function automatic logic [31:0] wrap_adr(input logic [31:0] base, input int i);
        logic [31:0] idx;
        idx = ((base >> 2) + i) & 32'h7;
        return (base & ~32'h1F) | (idx << 2);
    endfunction

    // Slave: responds after slv_waits idle cycles per beat, checks each accepted beat.
    always @(negedge clk) begin
        logic [73:0] e;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_rty_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o && !slv_silent) begin
            if (wcnt < slv_waits) begin
                wcnt++;
            end else begin
                wcnt = 0;
                if (bq.size() == 0) begin
                    chk("beat_unexpected", wbm_stb_o, 0);
                end else begin
                    e = bq.pop_front();
                    chk("bus_beat", {wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cti_o,
                                     wbm_bte_o, wbm_dat_o}, e);
                end
                if (beat == slv_err_beat) begin
                    wbm_err_i = !slv_rty;
                    wbm_rty_i = slv_rty;
                    wbm_ack_i = slv_ack_err;
                end else begin
                    wbm_ack_i = 1'b1;
                end
                wbm_dat_i = slv_fixed ? slv_val : (wbm_adr_o ^ 32'h5A5A_0000);
                beat++;
            end
        end else begin
            wcnt = 0;
            if (!wbm_cyc_o) beat = 0;
        end
    end

    // Read-data scoreboard: {expected cyc, expected dbus_dat_o} per ack pulse.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst && (dbus_ack_o || dbus_err_o))
            chk("ack_err_excl", dbus_ack_o & dbus_err_o, 0);
        if (rst && dbus_ack_o) begin
            if (dq.size() == 0) begin
                chk("ack_unexpected", dbus_ack_o, 0);
            end else begin
                e = dq.pop_front();
                chk("ack_cyc_data", {wbm_cyc_o, dbus_dat_o}, e);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic w, input logic b);
        @(negedge clk);
        dbus_req_i   = 1'b1;
        dbus_adr_i   = a;
        dbus_dat_i   = d;
        dbus_bsel_i  = s;
        dbus_we_i    = w;
        dbus_burst_i = b;
        req_cyc      = cyc_n;
    endtask

    task automatic run_wait(input int nacks, input bit hold_done);
        bit done;
        bit prev_stb;
        done = 0; prev_stb = 0;
        acks = 0; errs = 0;
        first_ack = -1; last_ack = -1; err_cyc = -1; stb_rise = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (wbm_stb_o && !prev_stb && stb_rise < 0) stb_rise = cyc_n;
            prev_stb = wbm_stb_o;
            if (dbus_ack_o) begin
                if (acks == 0) first_ack = cyc_n;
                last_ack = cyc_n;
                acks++;
                if (acks == nacks) done = 1;
            end
            if (dbus_err_o) begin
                errs++;
                err_cyc = cyc_n;
                chk("err_cyc_low", wbm_cyc_o, 0);
                done = 1;
            end
        end
        chk("wait_bound", done, 1);
        if (hold_done) @(negedge clk);
        dbus_req_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dbus_req_i = 0; dbus_adr_i = 0; dbus_dat_i = 0;
        dbus_bsel_i = 0; dbus_we_i = 0; dbus_burst_i = 0;
        wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", wbm_cyc_o, 0);

        // Single read, two wait states.
        slv_waits = 2; slv_fixed = 1; slv_val = 32'hDEAD_BEEF;
        bq.push_back(pk(32'h40, 4'hF, 0, 3'b000, 2'b00, 32'h0));
        dq.push_back({1'b0, 32'hDEAD_BEEF});
        issue(32'h40, 32'h0, 4'hF, 0, 0);
        run_wait(1, 0);
        chk("rd_acks", acks, 1);
        chk("rd_errs", errs, 0);
        chk("rd_latency", first_ack - req_cyc, 4);
        @(negedge clk);

        // Single write with burst flag set; request held through DONE.
        slv_waits = 0;
        bq.push_back(pk(32'h80, 4'h3, 1, 3'b000, 2'b00, 32'h1234_5678));
        dq.push_back({1'b0, 32'hDEAD_BEEF});
        issue(32'h80, 32'h1234_5678, 4'h3, 1, 1);
        run_wait(1, 1);
        chk("wr_acks", acks, 1);
        chk("wr_latency", first_ack - req_cyc, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wr_no_reissue", wbm_cyc_o, 0);
        end

        // Eight-beat wrapping burst from 0x118.
        slv_fixed = 0;
        for (int i = 0; i < 8; i++) begin
            bq.push_back(pk(wrap_adr(32'h118, i), 4'hF, 0,
                            (i == 7) ? 3'b111 : 3'b010, 2'b10, 32'h0));
            dq.push_back({(i != 7), wrap_adr(32'h118, i) ^ 32'h5A5A_0000});
        end
        issue(32'h118, 32'h0, 4'h1, 0, 1);
        run_wait(8, 0);
        chk("bst_acks", acks, 8);
        chk("bst_errs", errs, 0);
        chk("bst_first", first_ack - req_cyc, 2);
        chk("bst_consec", last_ack - first_ack, 7);
        @(negedge clk);

        // Error on the third beat.
        slv_err_beat = 2; slv_ack_err = 0;
        for (int i = 0; i < 3; i++)
            bq.push_back(pk(32'h200 + 32'(4 * i), 4'hF, 0, 3'b010, 2'b10, 32'h0));
        for (int i = 0; i < 2; i++)
            dq.push_back({1'b1, (32'h200 + 32'(4 * i)) ^ 32'h5A5A_0000});
        issue(32'h200, 32'h0, 4'hF, 0, 1);
        run_wait(8, 0);
        chk("err_acks", acks, 2);
        chk("err_errs", errs, 1);
        chk("err_follows", err_cyc - last_ack, 1);
        @(negedge clk);
        chk("err_idle", wbm_cyc_o, 0);

        // Ack and err together on the third beat.
        slv_ack_err = 1;
        for (int i = 0; i < 3; i++)
            bq.push_back(pk(wrap_adr(32'h3F0, i), 4'hF, 0, 3'b010, 2'b10, 32'h0));
        for (int i = 0; i < 2; i++)
            dq.push_back({1'b1, wrap_adr(32'h3F0, i) ^ 32'h5A5A_0000});
        issue(32'h3F0, 32'h0, 4'hF, 0, 1);
        run_wait(8, 0);
        chk("ackerr_acks", acks, 2);
        chk("ackerr_errs", errs, 1);
        @(negedge clk);

        // Retry on a single read.
        slv_err_beat = 0; slv_ack_err = 0; slv_rty = 1;
        bq.push_back(pk(32'h44, 4'hC, 0, 3'b000, 2'b00, 32'h0));
        issue(32'h44, 32'h0, 4'hC, 0, 0);
        run_wait(1, 0);
        chk("rty_acks", acks, 0);
        chk("rty_errs", errs, 1);
        slv_err_beat = -1; slv_rty = 0;
        @(negedge clk);

        // Silent slave: time-out.
        slv_silent = 1;
        issue(32'h48, 32'h0, 4'hF, 0, 0);
        run_wait(1, 0);
        chk("tmo_acks", acks, 0);
        chk("tmo_errs", errs, 1);
        chk("tmo_delay", err_cyc - stb_rise, 6);
        slv_silent = 0;
        @(negedge clk);

        // Reset asserted asynchronously after the fourth burst beat.
        for (int i = 0; i < 8; i++) begin
            bq.push_back(pk(wrap_adr(32'h400, i), 4'hF, 0,
                            (i == 7) ? 3'b111 : 3'b010, 2'b10, 32'h0));
            dq.push_back({(i != 7), wrap_adr(32'h400, i) ^ 32'h5A5A_0000});
        end
        issue(32'h400, 32'h0, 4'hF, 0, 1);
        run_wait(4, 0);
        chk("rstb_acks", acks, 4);
        #2 rst = 1'b0;
        #1 chk("rst_mid_outs", outs(), 0);
        dq.delete();
        bq.delete();
        @(negedge clk);
        chk("rst_no_resp", {dbus_ack_o, dbus_err_o}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_idle", wbm_cyc_o, 0);

        // Single read after reset release.
        slv_waits = 1; slv_fixed = 1; slv_val = 32'hCAFE_F00D;
        bq.push_back(pk(32'h44, 4'hF, 0, 3'b000, 2'b00, 32'h0));
        dq.push_back({1'b0, 32'hCAFE_F00D});
        issue(32'h44, 32'h0, 4'hF, 0, 0);
        run_wait(1, 0);
        chk("post_acks", acks, 1);
        chk("post_errs", errs, 0);
        chk("post_latency", first_ack - req_cyc, 3);

        repeat (2) @(negedge clk);
        chk("dq_drained", dq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
